// File: rtl/fg_fd_fifo_ext.sv
// Flow-descriptor FIFO with a registered output stage, almost-full flag, synchronous
// flush and optional drop-when-full mode with a saturating drop counter.
module fg_fd_fifo_ext #(
  parameter int ADDR_WIDTH         = 10,
  parameter int DEST_WIDTH         = 8,
  parameter int RATE_WIDTH         = 16,
  parameter int LEN_WIDTH          = 32,
  parameter int ALMOST_FULL_THRESH = 2**ADDR_WIDTH - 4,
  parameter int DROP_WHEN_FULL     = 0
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            flush,
  input  logic                            input_fd_valid,
  output logic                            input_fd_ready,
  input  logic [DEST_WIDTH-1:0]           input_fd_dest,
  input  logic [RATE_WIDTH-1:0]           input_fd_rate_num,
  input  logic [RATE_WIDTH-1:0]           input_fd_rate_denom,
  input  logic [LEN_WIDTH-1:0]            input_fd_len,
  input  logic [LEN_WIDTH-1:0]            input_fd_burst_len,
  output logic                            output_fd_valid,
  input  logic                            output_fd_ready,
  output logic [DEST_WIDTH-1:0]           output_fd_dest,
  output logic [RATE_WIDTH-1:0]           output_fd_rate_num,
  output logic [RATE_WIDTH-1:0]           output_fd_rate_denom,
  output logic [LEN_WIDTH-1:0]            output_fd_len,
  output logic [LEN_WIDTH-1:0]            output_fd_burst_len,
  output logic [ADDR_WIDTH:0]             count,
  output logic [ADDR_WIDTH+LEN_WIDTH-1:0] byte_count,
  output logic                            almost_full,
  output logic [31:0]                     drop_count
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam int W     = DEST_WIDTH + 2*RATE_WIDTH + 2*LEN_WIDTH;
  localparam int BW    = ADDR_WIDTH + LEN_WIDTH;
  localparam logic [ADDR_WIDTH:0] FULL_CNT = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] AF_TH    = (ADDR_WIDTH+1)'(ALMOST_FULL_THRESH);
  localparam bit DROP_MODE = (DROP_WHEN_FULL != 0);

  logic [W-1:0]          mem_q [DEPTH];
  logic [W-1:0]          out_q;
  logic [W-1:0]          in_word;
  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH:0]   mem_cnt_q, mem_cnt_d, count_q, count_d;
  logic [BW-1:0]         byte_q, byte_d;
  logic [31:0]           drop_q, drop_d;
  logic                  out_valid_q, out_valid_d, af_q, af_d;
  logic                  full, accept, deq, load, drop;

  assign in_word = {input_fd_dest, input_fd_rate_num, input_fd_rate_denom,
                    input_fd_len, input_fd_burst_len};
  assign {output_fd_dest, output_fd_rate_num, output_fd_rate_denom,
          output_fd_len, output_fd_burst_len} = out_q;

  assign full           = (count_q == FULL_CNT);
  assign input_fd_ready = !rst && !flush && (DROP_MODE || !full);
  assign deq            = out_valid_q && output_fd_ready && !flush && !rst;
  // In drop mode a full queue still takes the input when the head leaves this cycle.
  assign accept         = input_fd_valid && input_fd_ready && (!full || deq);
  assign drop           = DROP_MODE && input_fd_valid && input_fd_ready && full && !deq;
  assign load           = (mem_cnt_q != '0) && (!out_valid_q || deq) && !flush && !rst;

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    mem_cnt_d   = mem_cnt_q;
    count_d     = count_q;
    byte_d      = byte_q;
    out_valid_d = out_valid_q;
    drop_d      = drop_q;
    if (accept) wr_ptr_d = wr_ptr_q + 1'b1;
    if (load) rd_ptr_d = rd_ptr_q + 1'b1;
    if (accept && !load) mem_cnt_d = mem_cnt_q + 1'b1;
    else if (!accept && load) mem_cnt_d = mem_cnt_q - 1'b1;
    if (accept && !deq) count_d = count_q + 1'b1;
    else if (!accept && deq) count_d = count_q - 1'b1;
    byte_d = byte_q + (accept ? {{ADDR_WIDTH{1'b0}}, input_fd_len} : '0)
                    - (deq ? {{ADDR_WIDTH{1'b0}}, output_fd_len} : '0);
    if (load) out_valid_d = 1'b1;
    else if (deq) out_valid_d = 1'b0;
    if (drop && (drop_q != '1)) drop_d = drop_q + 1'b1;
    if (flush) begin
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      mem_cnt_d   = '0;
      count_d     = '0;
      byte_d      = '0;
      out_valid_d = 1'b0;
    end
    af_d = (count_d >= AF_TH);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      mem_cnt_q   <= '0;
      count_q     <= '0;
      byte_q      <= '0;
      out_valid_q <= 1'b0;
      af_q        <= 1'b0;
      drop_q      <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      mem_cnt_q   <= mem_cnt_d;
      count_q     <= count_d;
      byte_q      <= byte_d;
      out_valid_q <= out_valid_d;
      af_q        <= af_d;
      drop_q      <= drop_d;
    end
  end

  // Storage array is never reset so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (accept) mem_q[wr_ptr_q] <= in_word;
  end

  always_ff @(posedge clk) begin
    if (rst || flush) out_q <= '0;
    else if (load) out_q <= mem_q[rd_ptr_q];
  end

  assign output_fd_valid = out_valid_q;
  assign count           = count_q;
  assign byte_count      = byte_q;
  assign almost_full     = af_q;
  assign drop_count      = drop_q;

endmodule
